// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops that route through the adder and report carry/overflow
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops that compute a - b (inverted B, carry-in of one)
    function automatic logic is_negate(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle between a requester and the serial ALU controller.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while the controller is not busy.
interface serial_alu_ctrl_if
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carryout, overflow, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carryout, overflow, zero
    );
endinterface

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: AND/NOR/OR/XOR/NAND or full adder with optional B inversion.
// Latency: purely combinational.
// Backpressure: none.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       negate_i,
    input  logic [2:0] sel_i,
    output logic       y_o,
    output logic       cout_o
);
    logic b_eff;
    logic sum;

    // Full adder on (a, b^negate, cin) plus the bitwise functions, muxed by select
    always_comb begin
        b_eff  = b_i ^ negate_i;
        sum    = a_i ^ b_eff ^ cin_i;
        cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
        case (sel_i)
            OP_AND:  y_o = a_i & b_i;
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            default: y_o = sum;
        endcase
    end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: one WIDTH-bit op through a single 1-bit slice, LSB first.
// Latency: WIDTH+1 cycles from accepting edge to the done cycle; outputs registered.
// Backpressure: start ignored while busy; SLT enabled by defining SERIAL_ALU_SLT_EN.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)(
    input  logic               clk,
    input  logic               rst_n,
    serial_alu_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic             slice_y;
    logic             slice_cout;
    logic [2:0]       slice_sel;
    logic             slice_neg;
    logic             last_bit;
    logic             ovf_bit;
    logic [WIDTH-1:0] res_full;

    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    assign slice_sel = is_arith(op_q) ? OP_ADD : op_q;
    assign slice_neg = is_negate(op_q);
    // Carry into the MSB is the held carry while the MSB is being processed
    assign ovf_bit   = carry_q ^ slice_cout;
    // Current bit lands at the MSB; on the last bit this is the full word
    assign res_full  = {slice_y, res_sr_q};

    serial_alu_slice u_slice (
        .a_i      (a_sr_q[0]),
        .b_i      (b_sr_q[0]),
        .cin_i    (carry_q),
        .negate_i (slice_neg),
        .sel_i    (slice_sel),
        .y_o      (slice_y),
        .cout_o   (slice_cout)
    );

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            res_sr_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            res_sr_q   <= res_sr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    // Next state: accept in IDLE/DONE, leave RUN after the MSB
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = bus.start ? RUN : IDLE;
            RUN:        if (last_bit) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath: latch on accept, shift one bit per RUN cycle, publish on the MSB
    always_comb begin
        op_d       = op_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        res_sr_d   = res_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        if (state_q == RUN) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_full[WIDTH-1:1];
            carry_d  = slice_cout;
            cnt_d    = cnt_q + 1'b1;
            if (last_bit) begin
                if (op_q == OP_SLT) begin
`ifdef SERIAL_ALU_SLT_EN
                    // Sign of the true difference: sum MSB corrected by overflow
                    result_d   = WIDTH'(slice_y ^ ovf_bit);
                    carryout_d = slice_cout;
                    overflow_d = ovf_bit;
`else
                    // Unsupported opcode still completes, with a cleared result
                    result_d   = '0;
                    carryout_d = 1'b0;
                    overflow_d = 1'b0;
`endif
                end else if (is_arith(op_q)) begin
                    result_d   = res_full;
                    carryout_d = slice_cout;
                    overflow_d = ovf_bit;
                end else begin
                    result_d   = res_full;
                    carryout_d = 1'b0;
                    overflow_d = 1'b0;
                end
                zero_d = (result_d == '0);
            end
        end else if (bus.start) begin
            op_d    = bus.op;
            a_sr_d  = bus.a;
            b_sr_d  = bus.b;
            cnt_d   = '0;
            carry_d = is_negate(bus.op);
        end
    end

    // Outputs decode from registered state only
    always_comb begin
        bus.busy     = (state_q == RUN);
        bus.done     = (state_q == DONE);
        bus.result   = result_q;
        bus.carryout = carryout_q;
        bus.overflow = overflow_q;
        bus.zero     = zero_q;
    end
endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial ALU controller. Runs a WIDTH-bit operation through a single 1-bit ALU slice, one bit per clock, LSB first. It holds the carry between bits, sequences the slice's op select, negate and carry-in, and reports the registered result and flags through a start/done handshake. It lets area-constrained datapaths share one slice across a full word operation.

## Interface
- WIDTH, 32, operand/result width; legal range 2..64
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- op  input  3  000 AND, 001 NOR, 010 OR, 011 XOR, 100 NAND, 101 ADD, 110 SUB, 111 SLT
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags valid
- result  output  WIDTH  registered result; held until the next completion
- carryout  output  1  carry out of the MSB for ADD/SUB/SLT; 0 for logic ops
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB) for ADD/SUB/SLT; 0 for logic ops
- zero  output  1  result == 0

## Operation
- States:
  - IDLE: no operation in progress.
  - RUN: one bit processed per cycle.
  - DONE: one cycle, done=1.
- IDLE/DONE with start=1: latch a, b and op into shift registers. Clear the bit counter. Set carry=1 for SUB/SLT, otherwise 0. Go to RUN. With start=0, go to (or stay in) IDLE.
- RUN, each cycle on bit i:
  - Drive the slice with a_sr[0], b_sr[0], carry, slice select and negate.
  - Slice select is op for logic ops, and the adder for ADD/SUB/SLT.
  - negate=1 for SUB/SLT.
  - Shift the slice output into the result shift register from the MSB side. Update carry. Shift the operands right by one.
- On bit WIDTH-1, capture the carry into the MSB (for overflow) and the final carry. At the same edge, write result and flags to the output registers and go to DONE.
- SLT: result = {WIDTH-1 zeros, sum_msb XOR overflow}. carryout and overflow are those of the subtraction. zero reflects the final result.
- start is ignored in RUN. Operands change freely after acceptance.
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, result=0, carryout=0, overflow=0, zero=0. Internal shift registers and counter are cleared.
- Reset mid-RUN aborts the operation. done is never produced for it, and outputs return to reset values.

## Timing
- start sampled high at edge 0 → busy=1 after edge 0.
- Bit i is committed at edge i+1.
- Edge WIDTH: result and flags updated, busy=0, done=1 for the cycle following edge WIDTH.
- Latency: WIDTH+1 cycles from the accepting edge to the done cycle.
- Back-to-back: start high during the DONE cycle is accepted. Throughput is one operation per WIDTH+1 cycles.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ALU_SLT_EN defined: op 111 performs SLT as specified.
- SERIAL_ALU_SLT_EN undefined: op 111 is illegal but still completes normally with the standard latency. It produces result=0, carryout=0, overflow=0, zero=1.
- All other ops are identical in both builds.

## Structure
- Package serial_alu_pkg holds:
  - opcode localparams (OP_AND … OP_SLT)
  - the state enum (IDLE, RUN, DONE)
  - the default WIDTH constant
  - the helper function classifying arithmetic ops
- One sub-module: serial_alu_slice. It is a combinational 1-bit slice producing the AND/NOR/OR/XOR/NAND outputs and a full-adder output with B-inversion on negate, selected by a 3-bit select. It also provides carryout.
- The controller instantiates exactly one slice.

## Test plan
WIDTH=8 in all scenarios.
- ADD a=8'h7F b=8'h01 → done at cycle 9 after start: result 8'h80, carryout 0, overflow 1, zero 0.
- SUB a=8'h05 b=8'h05 → result 8'h00, zero 1, carryout 1, overflow 0.
- SLT a=8'hFE b=8'h03 → result 8'h01. Then SLT a=8'h03 b=8'hFE → result 8'h00. When SERIAL_ALU_SLT_EN is undefined, both give result 8'h00, zero 1.
- NOR a=8'hF0 b=8'h0F → result 8'h00, zero 1, carryout 0, overflow 0. XOR on the same operands → 8'hFF.
- Protocol:
  - start pulsed with different operands at cycle 3 of RUN → ignored; original result delivered.
  - start held high through DONE → second operation accepted; second done exactly 9 cycles after the first.
- rst_n low for one edge during bit 3 of ADD a=8'h7F b=8'h01 → next cycle busy 0, done 0, all outputs 0, no done pulse. A following ADD 8'h01+8'h01 → 8'h02.
